k12a_clock_seq: RTL and testbench
=================================

// Module: k12a_clock_seq
// PURPOSE
//   Sequences the K12A CPU clock from sys_clock: cpu_clock runs as a two-phase cycle, high phase then low phase.
//   Adds run/halt/single-step control and per-cycle memory wait-state stretching of the low phase.
//   Generates async_write, a strobe confined to the last sys cycle of the low phase, and releases CPU reset.
//   Sits between the board clock/reset and the K12A core, memory and front-panel logic.
// PARAMETERS
//   WAIT_WIDTH    3  width of wait_states; max stretch = 2**WAIT_WIDTH-1 extra sys cycles
//   RESET_CYCLES  4  sys cycles cpu_reset_n stays low after reset_n deasserts (>=1)
// PORTS
//   sys_clock    in   1           system clock; all state changes on posedge
//   reset_n      in   1           synchronous, active-low reset
//   run_req      in   1           pulse: enter continuous run (ignored unless halted)
//   halt_req     in   1           pulse: stop at next CPU cycle boundary; latched until taken
//   step_req     in   1           pulse: execute exactly one CPU cycle (ignored unless halted)
//   wait_states  in   WAIT_WIDTH  extra low-phase sys cycles; sampled during the high phase
//   cpu_halt     in   1           core HALT indication; sampled in last low-phase cycle
//   cpu_clock    out  1           registered CPU clock
//   cpu_reset_n  out  1           registered active-low CPU reset
//   async_write  out  1           sys_clock & write_win; write_win registered, high only in the last low-phase cycle
//   running      out  1           1 while in continuous run (not step, not halted)
//   cycle_done   out  1           registered 1-sys-cycle pulse after each completed CPU cycle
// BEHAVIOUR
//   Reset (reset_n=0 at posedge): state=RESET, cnt=0, halt_pend=0, step_flag=0, all outputs 0.
//   States:
//     RESET: cpu_reset_n=0, cpu_clock=0. After RESET_CYCLES sys cycles: cpu_reset_n<=1, go to HALT.
//     HALT:  cpu_clock=0.
//       run_req: go to HIGH, running<=1.
//       step_req: go to HIGH, step_flag<=1.
//       run_req and step_req together: run wins.
//     HIGH:  cpu_clock=1 for exactly 1 sys cycle. cnt<=wait_states, then LOW.
//     LOW:   cpu_clock=0. While cnt!=0: cnt<=cnt-1.
//       When cnt==0 (last cycle; write_win=1): cycle_done<=1 next cycle.
//       Stop if halt_pend|cpu_halt|step_flag|!running: go to HALT; clear running, halt_pend, step_flag.
//       Otherwise go to HIGH.
//   Latency: CPU cycle = 2+wait_states sys cycles; wait_states=0 reproduces the plain divide-by-2 clock.
//   halt_req in any run state sets halt_pend. A halt_req arriving in the last LOW cycle still stops at that boundary.
//   halt_req in HALT or RESET is discarded; halt_pend never survives into HALT.
//   run_req/step_req outside HALT are discarded (no queueing).
//   halt_req and run_req together in HALT: run is taken; halt_req is discarded (pend only set in run states).
//   cnt never underflows; wait_states changes during LOW have no effect on the current cycle.
//   reset_n low mid-cycle: next posedge forces RESET. cpu_clock drops low and write_win clears, so async_write ends within 1 sys cycle.
//   async_write is 0 whenever write_win=0 or state is RESET/HALT. No combinational path from inputs except the sys_clock gate.
// STRUCTURE
//   k12a.inc.sv: add clkseq_state_t enum {CS_RESET, CS_HALT, CS_HIGH, CS_LOW} and CLKSEQ_RESET_CYCLES default.
//   Sub-module k12a_wait_counter: loadable WAIT_WIDTH down-counter with load, dec, zero flag.
//   Also reused for the RESET_CYCLES count (instantiate twice or share, implementer's choice).
//   Remainder: one ALWAYS_FF state register plus next-state logic.
// TESTING
//   1) reset_n low 3 cycles, then high, RESET_CYCLES=4 -> cpu_reset_n rises on 4th posedge after release; cpu_clock stays 0.
//   2) run_req pulse, wait_states=0 -> cpu_clock 1,0,1,0...; cycle_done every 2 cycles; async_write only in sys_clock-high half of low phase.
//   3) run with wait_states=3 -> high 1 cycle, low 4 cycles; write_win only in 4th low cycle; cycle_done period 5.
//   4) halt_req in HIGH, then in last LOW cycle (separate runs) -> both stop at that cycle's boundary; running=0.
//   5) step_req while halted -> exactly one cpu_clock high pulse, one cycle_done, back to HALT; step_req while running -> no effect.
//   6) reset_n low during LOW with cnt=2 -> next posedge all outputs 0, async_write 0; cpu_halt=1 in last LOW cycle -> HALT.

Source files
------------

// File: rtl/k12a_clock_seq_pkg.sv
// rtl/k12a_clock_seq_pkg.sv - shared types and defaults for the K12A clock sequencer
// Contents:
//   clkseq_state_t       sequencer states: reset hold, halted, clock high phase, clock low phase
//   CLKSEQ_RESET_CYCLES  default number of sys cycles the CPU reset is held after board reset
//   CLKSEQ_WAIT_WIDTH    default width of the wait-state input
package k12a_clock_seq_pkg;

    typedef enum logic [1:0] {
        CS_RESET = 2'd0,
        CS_HALT  = 2'd1,
        CS_HIGH  = 2'd2,
        CS_LOW   = 2'd3
    } clkseq_state_t;

    localparam int CLKSEQ_RESET_CYCLES = 4;
    localparam int CLKSEQ_WAIT_WIDTH   = 3;

endpackage

// File: rtl/k12a_wait_counter.sv
// rtl/k12a_wait_counter.sv - loadable saturating down-counter with zero flag
// Ports:
//   clk         clock, all changes on posedge
//   resetn      synchronous active-low reset, loads RESET_VALUE
//   load        load load_value (has priority over dec)
//   load_value  value to load
//   dec         decrement by one; holds at zero, never wraps
//   count       current count
//   zero        count == 0
module k12a_wait_counter #(
    parameter int               WIDTH       = 3,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count <= RESET_VALUE;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/k12a_clock_seq.sv
// rtl/k12a_clock_seq.sv - K12A CPU clock sequencer with run/halt/step and wait-state stretching
// Ports:
//   sys_clock    system clock, all state changes on posedge
//   reset_n      synchronous active-low reset
//   run_req      pulse: start continuous run (only honoured while halted)
//   halt_req     pulse: stop at the next CPU cycle boundary (held until taken)
//   step_req     pulse: run exactly one CPU cycle (only honoured while halted)
//   wait_states  extra low-phase sys cycles, captured during the high phase
//   cpu_halt     core HALT indication, looked at in the last low-phase cycle
//   cpu_clock    registered CPU clock
//   cpu_reset_n  registered active-low CPU reset
//   async_write  sys_clock gated by the registered last-low-cycle write window
//   running      continuous run in progress
//   cycle_done   one sys-cycle pulse after each completed CPU cycle
module k12a_clock_seq
    import k12a_clock_seq_pkg::*;
#(
    parameter int WAIT_WIDTH   = CLKSEQ_WAIT_WIDTH,
    parameter int RESET_CYCLES = CLKSEQ_RESET_CYCLES
) (
    input  logic                  sys_clock,
    input  logic                  reset_n,
    input  logic                  run_req,
    input  logic                  halt_req,
    input  logic                  step_req,
    input  logic [WAIT_WIDTH-1:0] wait_states,
    input  logic                  cpu_halt,
    output logic                  cpu_clock,
    output logic                  cpu_reset_n,
    output logic                  async_write,
    output logic                  running,
    output logic                  cycle_done
);

    // Reset hold counter starts at RESET_CYCLES-1 so the release happens on
    // the RESET_CYCLES-th posedge after reset_n goes high.
    localparam int              RCW     = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [RCW-1:0]  RC_INIT = RCW'(RESET_CYCLES - 1);

    clkseq_state_t         state, state_n;
    logic                  halt_pend, halt_pend_n;
    logic                  step_flag, step_flag_n;
    logic                  running_n;
    logic                  cpu_reset_n_n;
    logic                  write_win, write_win_n;

    logic                  wc_load, wc_dec, wc_zero;
    logic [WAIT_WIDTH-1:0] wc_count;
    logic                  rc_dec, rc_zero;
    logic [RCW-1:0]        rc_count;

    k12a_wait_counter #(.WIDTH(WAIT_WIDTH), .RESET_VALUE('0)) u_wait_cnt (
        .clk        (sys_clock),
        .resetn     (reset_n),
        .load       (wc_load),
        .load_value (wait_states),
        .dec        (wc_dec),
        .count      (wc_count),
        .zero       (wc_zero)
    );

    k12a_wait_counter #(.WIDTH(RCW), .RESET_VALUE(RC_INIT)) u_reset_cnt (
        .clk        (sys_clock),
        .resetn     (reset_n),
        .load       (1'b0),
        .load_value ('0),
        .dec        (rc_dec),
        .count      (rc_count),
        .zero       (rc_zero)
    );

    always_comb begin
        state_n       = state;
        halt_pend_n   = halt_pend;
        step_flag_n   = step_flag;
        running_n     = running;
        cpu_reset_n_n = cpu_reset_n;
        wc_load       = 1'b0;
        wc_dec        = 1'b0;
        rc_dec        = (state == CS_RESET) && (rc_count != '0);

        unique case (state)
            CS_RESET: begin
                if (rc_zero) begin
                    state_n       = CS_HALT;
                    cpu_reset_n_n = 1'b1;
                end
            end
            CS_HALT: begin
                // halt_req is dropped here; run beats step when both arrive.
                if (run_req) begin
                    state_n   = CS_HIGH;
                    running_n = 1'b1;
                end else if (step_req) begin
                    state_n     = CS_HIGH;
                    step_flag_n = 1'b1;
                end
            end
            CS_HIGH: begin
                wc_load = 1'b1;
                state_n = CS_LOW;
                if (halt_req) halt_pend_n = 1'b1;
            end
            CS_LOW: begin
                if (!wc_zero) begin
                    wc_dec = 1'b1;
                    if (halt_req) halt_pend_n = 1'b1;
                end else if (halt_pend || halt_req || cpu_halt || step_flag || !running) begin
                    state_n     = CS_HALT;
                    running_n   = 1'b0;
                    halt_pend_n = 1'b0;
                    step_flag_n = 1'b0;
                end else begin
                    state_n = CS_HIGH;
                end
            end
            default: state_n = CS_RESET;
        endcase

        // Window is set for the cycle in which the stretched low phase will
        // have reached zero: straight from HIGH with no wait states, or when
        // the counter is about to step from 1 to 0.
        write_win_n = (state_n == CS_LOW) &&
                      (wc_load ? (wait_states == '0) : (wc_count == WAIT_WIDTH'(1)));
    end

    always_ff @(posedge sys_clock) begin
        if (!reset_n) begin
            state       <= CS_RESET;
            halt_pend   <= 1'b0;
            step_flag   <= 1'b0;
            running     <= 1'b0;
            cpu_clock   <= 1'b0;
            cpu_reset_n <= 1'b0;
            write_win   <= 1'b0;
            cycle_done  <= 1'b0;
        end else begin
            state       <= state_n;
            halt_pend   <= halt_pend_n;
            step_flag   <= step_flag_n;
            running     <= running_n;
            cpu_clock   <= (state_n == CS_HIGH);
            cpu_reset_n <= cpu_reset_n_n;
            write_win   <= write_win_n;
            cycle_done  <= (state == CS_LOW) && wc_zero;
        end
    end

    assign async_write = sys_clock & write_win;

endmodule

// File: tb/tb_k12a_clock_seq.sv
// tb/tb_k12a_clock_seq.sv - directed vector bench for k12a_clock_seq
module tb_k12a_clock_seq;

    logic       sys_clock = 1'b0;
    logic       reset_n   = 1'b0;
    logic       run_req   = 1'b0;
    logic       halt_req  = 1'b0;
    logic       step_req  = 1'b0;
    logic [2:0] wait_states = 3'd0;
    logic       cpu_halt  = 1'b0;
    logic       cpu_clock, cpu_reset_n, async_write, running, cycle_done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 sys_clock = ~sys_clock;

    k12a_clock_seq #(.WAIT_WIDTH(3), .RESET_CYCLES(4)) dut (
        .sys_clock   (sys_clock),
        .reset_n     (reset_n),
        .run_req     (run_req),
        .halt_req    (halt_req),
        .step_req    (step_req),
        .wait_states (wait_states),
        .cpu_halt    (cpu_halt),
        .cpu_clock   (cpu_clock),
        .cpu_reset_n (cpu_reset_n),
        .async_write (async_write),
        .running     (running),
        .cycle_done  (cycle_done)
    );

    typedef struct {
        logic       rst_n, run, halt, step, chalt;
        logic [2:0] ws;
        logic       cc, crn, aw, rn, cd;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst_n, run, halt, step, chalt, input logic [2:0] ws,
                       input logic cc, crn, aw, rn, cd);
        vec_t v;
        v.rst_n = rst_n; v.run = run; v.halt = halt; v.step = step; v.chalt = chalt; v.ws = ws;
        v.cc = cc; v.crn = crn; v.aw = aw; v.rn = rn; v.cd = cd;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    initial begin
        int cd_at[2];
        int n_cd;
        int n_aw;
        bit seen;

        //   rst run hlt stp chl ws   cc crn aw rn cd
        add(0, 0, 0, 0, 0, 3'd0,  0, 0, 0, 0, 0);   // reset held 3 cycles
        add(0, 0, 0, 0, 0, 3'd0,  0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 3'd0,  0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 3'd0,  0, 0, 0, 0, 0);   // release: posedges 1..3 still in reset
        add(1, 0, 0, 0, 0, 3'd0,  0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 3'd0,  0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 3'd0,  0, 1, 0, 0, 0);   // 4th posedge: cpu_reset_n rises
        add(1, 0, 0, 0, 0, 3'd0,  0, 1, 0, 0, 0);
        add(1, 1, 0, 0, 0, 3'd0,  1, 1, 0, 1, 0);   // run, ws=0: divide by 2
        add(1, 0, 0, 0, 0, 3'd0,  0, 1, 1, 1, 0);
        add(1, 0, 0, 0, 0, 3'd0,  1, 1, 0, 1, 1);
        add(1, 0, 0, 0, 0, 3'd0,  0, 1, 1, 1, 0);
        add(1, 0, 0, 0, 0, 3'd0,  1, 1, 0, 1, 1);
        add(1, 0, 0, 0, 0, 3'd3,  0, 1, 0, 1, 0);   // ws=3 captured in HIGH
        add(1, 0, 0, 0, 0, 3'd5,  0, 1, 0, 1, 0);   // ws changes in LOW ignored
        add(1, 0, 0, 0, 0, 3'd0,  0, 1, 0, 1, 0);
        add(1, 0, 0, 0, 0, 3'd7,  0, 1, 1, 1, 0);   // write window in 4th low cycle
        add(1, 0, 0, 0, 0, 3'd0,  1, 1, 0, 1, 1);
        add(1, 0, 0, 0, 0, 3'd0,  0, 1, 1, 1, 0);
        add(1, 0, 0, 0, 0, 3'd0,  1, 1, 0, 1, 1);
        add(1, 0, 1, 0, 0, 3'd0,  0, 1, 1, 1, 0);   // halt_req in HIGH
        add(1, 0, 0, 0, 0, 3'd0,  0, 1, 0, 0, 1);   // stopped at boundary
        add(1, 0, 0, 0, 0, 3'd0,  0, 1, 0, 0, 0);
        add(1, 0, 0, 1, 0, 3'd0,  1, 1, 0, 0, 0);   // single step
        add(1, 0, 0, 0, 0, 3'd0,  0, 1, 1, 0, 0);
        add(1, 0, 0, 0, 0, 3'd0,  0, 1, 0, 0, 1);
        add(1, 0, 0, 0, 0, 3'd0,  0, 1, 0, 0, 0);
        add(1, 0, 1, 0, 0, 3'd0,  0, 1, 0, 0, 0);   // halt_req in HALT discarded
        add(1, 1, 0, 0, 0, 3'd0,  1, 1, 0, 1, 0);
        add(1, 0, 0, 0, 0, 3'd0,  0, 1, 1, 1, 0);
        add(1, 0, 0, 0, 0, 3'd0,  1, 1, 0, 1, 1);   // no stale halt
        add(1, 0, 0, 1, 0, 3'd0,  0, 1, 1, 1, 0);   // step while running: no effect
        add(1, 0, 0, 0, 0, 3'd0,  1, 1, 0, 1, 1);
        add(1, 0, 0, 0, 0, 3'd0,  0, 1, 1, 1, 0);
        add(1, 0, 0, 0, 1, 3'd0,  0, 1, 0, 0, 1);   // cpu_halt in last LOW
        add(1, 0, 0, 0, 0, 3'd0,  0, 1, 0, 0, 0);
        add(1, 1, 1, 0, 0, 3'd0,  1, 1, 0, 1, 0);   // run+halt in HALT: run taken
        add(1, 0, 0, 0, 0, 3'd0,  0, 1, 1, 1, 0);
        add(1, 0, 0, 0, 0, 3'd0,  1, 1, 0, 1, 1);
        add(1, 0, 0, 0, 0, 3'd0,  0, 1, 1, 1, 0);
        add(1, 0, 1, 0, 0, 3'd0,  0, 1, 0, 0, 1);   // halt_req in last LOW stops here
        add(1, 1, 0, 1, 0, 3'd0,  1, 1, 0, 1, 0);   // run+step: run wins
        add(1, 0, 0, 0, 0, 3'd0,  0, 1, 1, 1, 0);
        add(1, 0, 0, 0, 0, 3'd0,  1, 1, 0, 1, 1);
        add(1, 0, 0, 0, 0, 3'd3,  0, 1, 0, 1, 0);   // LOW cnt=3
        add(1, 0, 0, 0, 0, 3'd3,  0, 1, 0, 1, 0);   // LOW cnt=2
        add(0, 0, 0, 0, 0, 3'd3,  0, 0, 0, 0, 0);   // reset mid-LOW
        add(1, 0, 0, 0, 0, 3'd0,  0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 3'd0,  0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 3'd0,  0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 3'd0,  0, 1, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            reset_n     = vecs[i].rst_n;
            run_req     = vecs[i].run;
            halt_req    = vecs[i].halt;
            step_req    = vecs[i].step;
            cpu_halt    = vecs[i].chalt;
            wait_states = vecs[i].ws;
            @(posedge sys_clock); #1;
            chk("cpu_clock",   i, 32'(cpu_clock),   32'(vecs[i].cc));
            chk("cpu_reset_n", i, 32'(cpu_reset_n), 32'(vecs[i].crn));
            chk("async_write", i, 32'(async_write), 32'(vecs[i].aw));
            chk("running",     i, 32'(running),     32'(vecs[i].rn));
            chk("cycle_done",  i, 32'(cycle_done),  32'(vecs[i].cd));
            @(negedge sys_clock); #1;
            chk("async_write_low_half", i, 32'(async_write), 32'd0);
        end

        // Maximum stretch: CPU cycle of 2+7 sys cycles, one write strobe each.
        run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0; cpu_halt = 1'b0;
        wait_states = 3'd7;
        run_req = 1'b1;
        @(posedge sys_clock); #1;
        run_req = 1'b0;
        chk("max_run_high", 100, 32'(cpu_clock), 32'd1);
        n_cd = 0; n_aw = 0; cd_at[0] = 0; cd_at[1] = 0;
        for (int k = 0; k < 40 && n_cd < 2; k++) begin
            @(posedge sys_clock); #1;
            if (async_write) n_aw++;
            if (cycle_done) begin
                cd_at[n_cd] = k;
                n_cd++;
            end
        end
        chk("max_cycle_done_count", 101, 32'(n_cd), 32'd2);
        chk("max_cycle_period",     102, 32'(cd_at[1] - cd_at[0]), 32'd9);
        chk("max_write_strobes",    103, 32'(n_aw), 32'd2);

        // halt_req in the middle of a stretched LOW stops at that cycle's end.
        @(posedge sys_clock); #1;
        halt_req = 1'b1;
        @(posedge sys_clock); #1;
        halt_req = 1'b0;
        chk("mid_low_still_running", 104, 32'(running), 32'd1);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(posedge sys_clock); #1;
            if (cycle_done) seen = 1'b1;
        end
        chk("mid_low_halt_done_seen", 105, 32'(seen), 32'd1);
        chk("mid_low_halt_running",   106, 32'(running), 32'd0);
        chk("mid_low_halt_cpu_clock", 107, 32'(cpu_clock), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge sys_clock); #1;
            chk("halted_clock_quiet", 108 + k, 32'(cpu_clock), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
